multicycle_control_fsm: RTL

//  Moore control FSM for the multicycle CPU; drives every Datapath control input from opcode.

---
 rtl/multicycle_control_fsm.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control sequencer driving every Datapath control input from the opcode.
// Latency: BEQ/J 3, R/ADDI/SW 4, LW 5 cycles per instruction; each mem_ready-low cycle adds one.
// Backpressure: mem_ready low holds MEM_RD/MEM_WR; build option ILLEGAL_TRAP_EN selects trap vs NOP on bad opcodes.
module multicycle_control_fsm #(
  parameter int OPW  = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  output logic            SelectIns,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            BEQ,
  output logic [1:0]      PCSrc,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic            instr_done,
  output logic            illegal,
  output logic [ST_W-1:0] state_dbg
);

  localparam logic [OPW-1:0] OpR    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OpAddi = OPW'(6'b001000);
  localparam logic [OPW-1:0] OpLw   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OpSw   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OpBeq  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OpJ    = OPW'(6'b000010);

  typedef enum logic [3:0] {
    Idle    = 4'd0,
    Fetch   = 4'd1,
    Decode  = 4'd2,
    ExecR   = 4'd3,
    WbR     = 4'd4,
    ExecI   = 4'd5,
    WbI     = 4'd6,
    MemAddr = 4'd7,
    MemRd   = 4'd8,
    WbMem   = 4'd9,
    MemWr   = 4'd10,
    Branch  = 4'd11,
    Jump    = 4'd12,
    Trap    = 4'd13
  } state_t;

  state_t state;
  state_t stateNext;

  // State register; reset drops straight to Idle so no partial write can complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= Idle;
    else        state <= stateNext;
  end

  // Next-state routing and per-state control decode; everything not named in a state stays 0.
  always_comb begin
    stateNext  = Idle;
    SelectIns  = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    BEQ        = 1'b0;
    PCSrc      = 2'b00;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    case (state)
      Idle: stateNext = Fetch;
      Fetch: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b01;
        stateNext = Decode;
      end
      Decode: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        ALUSrcB = 2'b11;
        if (opcode == OpR)                         stateNext = ExecR;
        else if (opcode == OpAddi)                 stateNext = ExecI;
        else if (opcode == OpLw || opcode == OpSw) stateNext = MemAddr;
        else if (opcode == OpBeq)                  stateNext = Branch;
        else if (opcode == OpJ)                    stateNext = Jump;
        else begin
`ifdef ILLEGAL_TRAP_EN
          stateNext = Trap;
`else
          // Unknown opcode retires as a NOP straight from decode.
          instr_done = 1'b1;
          stateNext  = Fetch;
`endif
        end
      end
      ExecR: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        stateNext = WbR;
      end
      WbR: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        stateNext  = Fetch;
      end
      ExecI: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        stateNext = WbI;
      end
      WbI: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        stateNext  = Fetch;
      end
      MemAddr: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        stateNext = (opcode == OpLw) ? MemRd : MemWr;
      end
      MemRd: begin
        SelectIns = 1'b1;
        stateNext = mem_ready ? WbMem : MemRd;
      end
      WbMem: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        stateNext  = Fetch;
      end
      MemWr: begin
        // Strobe held through every wait; done only on the accepting cycle so it stays a single pulse.
        SelectIns  = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        stateNext  = mem_ready ? Fetch : MemWr;
      end
      Branch: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        BEQ        = 1'b1;
        PCSrc      = 2'b01;
        instr_done = 1'b1;
        stateNext  = Fetch;
      end
      Jump: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
        stateNext  = Fetch;
      end
`ifdef ILLEGAL_TRAP_EN
      Trap: stateNext = Trap;
`endif
      default: stateNext = Idle;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == Trap);
`else
  assign illegal = 1'b0;
`endif

  assign state_dbg = ST_W'(state);

endmodule
